// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a FIFO and sends them LSB first on a UART line (8N1 / 8N2).
// Optional feature macro FIFO_TX_PARITY_EN adds an even-parity bit after the data bits.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_en,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  output logic       fifo_rd,
  output logic       tx,
  output logic       busy,
  output logic       frame_done
);

  localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

`ifdef FIFO_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  state_t           state_r;
  logic [CNT_W-1:0] baud_cnt_r;
  logic [2:0]       bit_idx_r;
  logic             stop_cnt_r;
  logic [7:0]       shift_r;
  logic             tx_r;
  logic             busy_r;
  logic             fifo_rd_r;
  logic             frame_done_r;
  logic             bit_end_s;
`ifdef FIFO_TX_PARITY_EN
  logic             parity_r;
`endif

  assign bit_end_s  = (baud_cnt_r == CNT_LAST);
  assign fifo_rd    = fifo_rd_r;
  assign tx         = tx_r;
  assign busy       = busy_r;
  assign frame_done = frame_done_r;

  // Frame sequencer: state, bit timing, shifter and every registered output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      baud_cnt_r   <= '0;
      bit_idx_r    <= 3'd0;
      stop_cnt_r   <= 1'b0;
      shift_r      <= 8'h00;
      tx_r         <= 1'b1;
      busy_r       <= 1'b0;
      fifo_rd_r    <= 1'b0;
      frame_done_r <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      fifo_rd_r    <= 1'b0;
      frame_done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          baud_cnt_r <= '0;
          bit_idx_r  <= 3'd0;
          stop_cnt_r <= 1'b0;
          if (tx_en && !fifo_empty) begin
            // The pop strobe rides along with the capture, so the FIFO advances once per frame
            shift_r   <= fifo_dout;
`ifdef FIFO_TX_PARITY_EN
            parity_r  <= even_parity(fifo_dout);
`endif
            state_r   <= ST_START;
            tx_r      <= 1'b0;
            busy_r    <= 1'b1;
            fifo_rd_r <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end

        ST_START: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            state_r    <= ST_DATA;
            tx_r       <= shift_r[0];
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        ST_DATA: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (bit_idx_r == 3'd7) begin
              bit_idx_r <= 3'd0;
`ifdef FIFO_TX_PARITY_EN
              state_r   <= ST_PARITY;
              tx_r      <= parity_r;
`else
              state_r   <= ST_STOP;
              tx_r      <= 1'b1;
`endif
            end else begin
              // tx is registered, so drive the bit that becomes the LSB after this shift
              bit_idx_r <= bit_idx_r + 3'd1;
              shift_r   <= {1'b0, shift_r[7:1]};
              tx_r      <= shift_r[1];
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

`ifdef FIFO_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            state_r    <= ST_STOP;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
`endif

        ST_STOP: begin
          tx_r <= 1'b1;
          if (bit_end_s) begin
            baud_cnt_r <= '0;
            if (stop_cnt_r == STOP_LAST) begin
              stop_cnt_r   <= 1'b0;
              state_r      <= ST_IDLE;
              busy_r       <= 1'b0;
              frame_done_r <= 1'b1;
            end else begin
              stop_cnt_r <= stop_cnt_r + 1'b1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r    <= ST_IDLE;
          baud_cnt_r <= '0;
          bit_idx_r  <= 3'd0;
          stop_cnt_r <= 1'b0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds bytes, a scoreboard queue holds the expected bytes,
// and every frame on tx is checked cycle by cycle against the framing those bytes imply.
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_TX_PARITY_EN
  localparam int SB  = 2;
  localparam int PAR = 1;
`else
  localparam int SB  = 1;
  localparam int PAR = 0;
`endif
  localparam int NBITS = 9 + PAR + SB;
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_en;
  logic [7:0] fifo_dout;
  logic       fifo_empty;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  logic [7:0] mem [0:15];
  int         wr_ptr  = 0;
  int         rd_ptr  = 0;
  int         cyc     = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q [$];

  fifo_uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tx_en      (tx_en),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_dout  = mem[rd_ptr[3:0]];

  // FIFO read side and cycle counter
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd && !fifo_empty) rd_ptr <= rd_ptr + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr[3:0]] = b;
    wr_ptr++;
    exp_q.push_back(b);
  endtask

  task automatic wait_start(output int t0);
    int k = 0;
    while (tx !== 1'b0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("start_seen", tx, 32'd0);
    t0 = cyc;
  endtask

  // Entered anywhere before a frame; leaves one cycle after the frame_done pulse
  task automatic recv_frame(input string tag, output int t0);
    logic [7:0]  exp_b;
    logic [7:0]  got_b;
    logic [15:0] fb;
    int          shape_err;
    int          bsy;
    int          rd_err;
    int          fd_err;
`ifdef FIFO_TX_PARITY_EN
    logic        par_s;
    par_s = 1'b0;
`endif
    shape_err = 0;
    bsy       = 0;
    rd_err    = 0;
    fd_err    = 0;
    got_b     = 8'h00;
    exp_b     = 8'h00;
    wait_start(t0);
    check({tag, "_rd"}, fifo_rd, 32'd1);
    if (exp_q.size() > 0) exp_b = exp_q.pop_front();
    fb       = 16'hFFFF;
    fb[0]    = 1'b0;
    fb[8:1]  = exp_b;
`ifdef FIFO_TX_PARITY_EN
    fb[9]    = ^exp_b;
`endif
    for (int i = 0; i < FRAME; i++) begin
      if (tx !== fb[i / CPB]) shape_err++;
      if (busy === 1'b1) bsy++;
      if (i > 0 && fifo_rd !== 1'b0) rd_err++;
      if (frame_done !== 1'b0) fd_err++;
      if (i % CPB == CPB / 2) begin
        if (i / CPB >= 1 && i / CPB <= 8) got_b[i / CPB - 1] = tx;
`ifdef FIFO_TX_PARITY_EN
        if (i / CPB == 9) par_s = tx;
`endif
      end
      @(negedge clk);
    end
    check({tag, "_byte"}, got_b, exp_b);
    check({tag, "_shape"}, shape_err, 32'd0);
    check({tag, "_busy_len"}, bsy, FRAME);
    check({tag, "_rd_once"}, rd_err, 32'd0);
    check({tag, "_done_early"}, fd_err, 32'd0);
`ifdef FIFO_TX_PARITY_EN
    check({tag, "_parity"}, par_s, ^exp_b);
`endif
    check({tag, "_done"}, frame_done, 32'd1);
    check({tag, "_busy_end"}, busy, 32'd0);
    check({tag, "_tx_end"}, tx, 32'd1);
    @(negedge clk);
    check({tag, "_done_pulse"}, frame_done, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, r0, viol;
    rst_n = 1'b0;
    tx_en = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 32'd1);
    check("rst_busy", busy, 32'd0);
    check("rst_rd", fifo_rd, 32'd0);
    check("rst_done", frame_done, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single frame of 0x55
    tx_en = 1'b1;
    r0 = rd_ptr;
    push(8'h55);
    recv_frame("t1", t0);
    check("t1_pops", rd_ptr - r0, 32'd1);

    // Back-to-back frames with one idle cycle between them
    r0 = rd_ptr;
    push(8'hA3);
    push(8'h00);
    push(8'hFF);
    recv_frame("t2a", t0);
    recv_frame("t2b", t1);
    recv_frame("t2c", t2);
    check("t2_gap1", t1 - t0, FRAME + 1);
    check("t2_gap2", t2 - t1, FRAME + 1);
    check("t2_pops", rd_ptr - r0, 32'd3);

    // Empty FIFO keeps the line quiet
    viol = 0;
    repeat (200) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0 || frame_done !== 1'b0) viol++;
    end
    check("t3_quiet", viol, 32'd0);

    // tx_en dropped mid-frame: frame finishes, no new pop until re-enabled
    r0 = rd_ptr;
    push(8'h0F);
    push(8'h11);
    fork
      recv_frame("t4", t0);
      begin
        repeat (10) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    viol = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("t4_hold", viol, 32'd0);
    check("t4_pops", rd_ptr - r0, 32'd1);
    tx_en = 1'b1;
    @(negedge clk);
    check("t4_resume", tx, 32'd0);
    recv_frame("t4b", t0);

    // Reset mid-frame: the popped byte is lost, the next one is sent
    r0 = rd_ptr;
    push(8'h5A);
    push(8'h3C);
    wait_start(t0);
    check("t5_rd", fifo_rd, 32'd1);
    exp_q.delete(0);
    repeat (15) @(negedge clk);
    check("t5_busy_pre", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t5_async_tx", tx, 32'd1);
    check("t5_async_busy", busy, 32'd0);
    check("t5_async_rd", fifo_rd, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    recv_frame("t5", t0);
    check("t5_pops", rd_ptr - r0, 32'd2);

`ifdef FIFO_TX_PARITY_EN
    // Parity build: 0x07 has odd weight, 0x03 even
    push(8'h07);
    push(8'h03);
    recv_frame("t6a", t0);
    recv_frame("t6b", t1);
    check("t6_gap", t1 - t0, FRAME + 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
